wb_write_arbiter: RTL and testbench

//  Writeback-side initiator for the register file's single write port. Accepts results from
//  two producers (ALU and memory/load unit) through valid/ready, buffers each in its own FIFO,
//  and round-robin serialises them onto write_en/write_addr/write_data (one write per cycle).

---
 rtl/wb_write_arbiter.sv | 172 +++++++++++++++++
 tb/tb_wb_write_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_write_arbiter.sv
// Register-file writeback arbiter: two buffered producers (ALU, load unit) are round-robin
// serialised onto one registered write port, with a pending-write query for hazard detection.

module wb_write_arbiter_fifo #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [ADDR_W-1:0] rd_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] query_addr_i,
    output logic              ready_o,
    output logic              nempty_o,
    output logic [ADDR_W-1:0] head_rd_o,
    output logic [DATA_W-1:0] head_data_o,
    output logic              hit_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] rd_mem_r   [DEPTH];
    logic [DATA_W-1:0] data_mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              full_s;
    logic              push_ok_s;
    logic              pop_ok_s;
    logic              hit_s;

    // Full is judged on the registered count only, so a same-cycle pop never frees a slot early.
    assign full_s      = (count_r == CNT_W'(DEPTH));
    assign push_ok_s   = push_i && !full_s;
    assign pop_ok_s    = pop_i && (count_r != {CNT_W{1'b0}});
    assign ready_o     = !full_s;
    assign nempty_o    = (count_r != {CNT_W{1'b0}});
    assign head_rd_o   = rd_mem_r[rd_ptr_r];
    assign head_data_o = data_mem_r[rd_ptr_r];
    assign hit_o       = hit_s;

    // Pointer and occupancy state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(push_ok_s);
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_ok_s);
            count_r  <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
        end
    end

    // Entry storage; validity is tracked by the pointers, so no reset is needed here.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            rd_mem_r[wr_ptr_r]   <= rd_i;
            data_mem_r[wr_ptr_r] <= data_i;
        end
    end

    // Match the query against every occupied slot, walking from the head.
    always_comb begin
        hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_s = hit_s | ((CNT_W'(i) < count_r) &&
                             (rd_mem_r[rd_ptr_r + PTR_W'(i)] == query_addr_i));
        end
    end
endmodule

module wb_write_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              alu_valid_i,
    input  logic [ADDR_W-1:0] alu_rd_i,
    input  logic [DATA_W-1:0] alu_data_i,
    output logic              alu_ready_o,
    input  logic              mem_valid_i,
    input  logic [ADDR_W-1:0] mem_rd_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              mem_ready_o,
    output logic              write_en_o,
    output logic [ADDR_W-1:0] write_addr_o,
    output logic [DATA_W-1:0] write_data_o,
    input  logic [ADDR_W-1:0] query_addr_i,
    output logic              pending_o
);
    logic              alu_nempty_s, mem_nempty_s;
    logic [ADDR_W-1:0] alu_head_rd_s, mem_head_rd_s;
    logic [DATA_W-1:0] alu_head_data_s, mem_head_data_s;
    logic              alu_hit_s, mem_hit_s;
    logic              grant_alu_s, grant_mem_s;
    logic [ADDR_W-1:0] sel_rd_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              rr_mem_first_r;
    logic              write_en_r;
    logic [ADDR_W-1:0] write_addr_r;
    logic [DATA_W-1:0] write_data_r;

    wb_write_arbiter_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_alu_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(alu_valid_i), .rd_i(alu_rd_i), .data_i(alu_data_i),
        .pop_i(grant_alu_s), .query_addr_i(query_addr_i), .ready_o(alu_ready_o),
        .nempty_o(alu_nempty_s), .head_rd_o(alu_head_rd_s), .head_data_o(alu_head_data_s),
        .hit_o(alu_hit_s)
    );

    wb_write_arbiter_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_mem_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push_i(mem_valid_i), .rd_i(mem_rd_i), .data_i(mem_data_i),
        .pop_i(grant_mem_s), .query_addr_i(query_addr_i), .ready_o(mem_ready_o),
        .nempty_o(mem_nempty_s), .head_rd_o(mem_head_rd_s), .head_data_o(mem_head_data_s),
        .hit_o(mem_hit_s)
    );

    // Round-robin grant: a lone non-empty source wins, otherwise the one not served last.
    always_comb begin
        grant_alu_s = 1'b0;
        grant_mem_s = 1'b0;
        if (alu_nempty_s && (!mem_nempty_s || !rr_mem_first_r)) begin
            grant_alu_s = 1'b1;
        end else if (mem_nempty_s) begin
            grant_mem_s = 1'b1;
        end else begin
            grant_mem_s = 1'b0;
        end
        sel_rd_s   = grant_mem_s ? mem_head_rd_s   : alu_head_rd_s;
        sel_data_s = grant_mem_s ? mem_head_data_s : alu_head_data_s;
    end

    // Priority pointer moves only when a grant is actually issued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_mem_first_r <= 1'b0;
        end else if (grant_alu_s) begin
            rr_mem_first_r <= 1'b1;
        end else if (grant_mem_s) begin
            rr_mem_first_r <= 1'b0;
        end else begin
            rr_mem_first_r <= rr_mem_first_r;
        end
    end

    // Writes to x0 consume their grant but leave the port address/data untouched.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            write_en_r   <= 1'b0;
            write_addr_r <= {ADDR_W{1'b0}};
            write_data_r <= {DATA_W{1'b0}};
        end else if ((grant_alu_s || grant_mem_s) && (sel_rd_s != {ADDR_W{1'b0}})) begin
            write_en_r   <= 1'b1;
            write_addr_r <= sel_rd_s;
            write_data_r <= sel_data_s;
        end else begin
            write_en_r   <= 1'b0;
        end
    end

    assign write_en_o   = write_en_r;
    assign write_addr_o = write_addr_r;
    assign write_data_o = write_data_r;
    assign pending_o    = (query_addr_i != {ADDR_W{1'b0}}) &&
                          (alu_hit_s || mem_hit_s ||
                           (write_en_r && (write_addr_r == query_addr_i)));
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: reset, latency, round-robin streaming, x0 drop,
// pending query and full-FIFO backpressure.

module tb_wb_write_arbiter;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        alu_valid_i, mem_valid_i;
    logic [4:0]  alu_rd_i, mem_rd_i, query_addr_i;
    logic [63:0] alu_data_i, mem_data_i;
    logic        alu_ready_o, mem_ready_o, write_en_o, pending_o;
    logic [4:0]  write_addr_o;
    logic [63:0] write_data_o;
    int          checks = 0;
    int          errors = 0;

    wb_write_arbiter #(.DATA_W(64), .ADDR_W(5), .DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .alu_ready_o(alu_ready_o),
        .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i),
        .mem_ready_o(mem_ready_o),
        .write_en_o(write_en_o), .write_addr_o(write_addr_o), .write_data_o(write_data_o),
        .query_addr_i(query_addr_i), .pending_o(pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        alu_valid_i = 1'b0;
        mem_valid_i = 1'b0;
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        tick;
    endtask

    // ALU uses rd 1 with data 1,2,3..; MEM uses rd 2 with data 101,102..
    task automatic stream(input int n_a, input int n_m, input int cycles, input bit chk_alt);
        int a_sent, m_sent, a_got, m_got, widx;
        bit a_rdy, m_rdy, a_low, m_low;
        a_sent = 0; m_sent = 0; a_got = 0; m_got = 0; widx = 0; a_low = 0; m_low = 0;
        alu_rd_i = 5'd1; mem_rd_i = 5'd2;
        alu_valid_i = 1'b1; alu_data_i = 64'd1;
        mem_valid_i = 1'b1; mem_data_i = 64'd101;
        a_rdy = alu_ready_o; m_rdy = mem_ready_o;
        for (int c = 0; c < cycles; c++) begin
            tick;
            if (alu_valid_i && a_rdy) a_sent++;
            if (mem_valid_i && m_rdy) m_sent++;
            if (!a_rdy) check("alu_ready_after_full", alu_ready_o,
                              write_en_o && (write_addr_o == 5'd1));
            if (!m_rdy) check("mem_ready_after_full", mem_ready_o,
                              write_en_o && (write_addr_o == 5'd2));
            if (write_en_o) begin
                if (write_addr_o == 5'd1) begin
                    check("alu_order", write_data_o, 64'd1 + 64'(a_got));
                    a_got++;
                end else begin
                    check("mem_addr", write_addr_o, 64'd2);
                    check("mem_order", write_data_o, 64'd101 + 64'(m_got));
                    m_got++;
                end
                if (chk_alt && widx < 12)
                    check("alternate", write_addr_o, (widx % 2 == 0) ? 64'd1 : 64'd2);
                widx++;
            end
            alu_valid_i = (a_sent < n_a);
            alu_data_i  = 64'd1 + 64'(a_sent);
            mem_valid_i = (m_sent < n_m);
            mem_data_i  = 64'd101 + 64'(m_sent);
            a_rdy = alu_ready_o;
            m_rdy = mem_ready_o;
            if (!a_rdy) a_low = 1'b1;
            if (!m_rdy) m_low = 1'b1;
        end
        check("alu_all_committed", 64'(a_got), 64'(n_a));
        check("mem_all_committed", 64'(m_got), 64'(n_m));
        check("alu_ready_dropped", 64'(a_low), 64'd1);
        check("mem_ready_dropped", 64'(m_low), 64'd1);
        check("idle_after_drain", write_en_o, 64'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        alu_rd_i = 5'd0; mem_rd_i = 5'd0; query_addr_i = 5'd0;
        alu_data_i = 64'd0; mem_data_i = 64'd0;
        repeat (2) tick;
        check("in_reset_wen", write_en_o, 64'd0);
        rst_i = 1'b0;
        tick;
        check("rst_wen", write_en_o, 64'd0);
        check("rst_addr", write_addr_o, 64'd0);
        check("rst_data", write_data_o, 64'd0);
        check("rst_alu_ready", alu_ready_o, 64'd1);
        check("rst_mem_ready", mem_ready_o, 64'd1);
        query_addr_i = 5'd3; #1;
        check("rst_pending", pending_o, 64'd0);

        // Reset pulse with three entries queued and one write on the port.
        alu_valid_i = 1'b1; alu_rd_i = 5'd7;  alu_data_i = 64'd77;
        mem_valid_i = 1'b1; mem_rd_i = 5'd8;  mem_data_i = 64'd88;
        tick;
        alu_rd_i = 5'd9;  alu_data_i = 64'd99;
        mem_rd_i = 5'd10; mem_data_i = 64'd1010;
        tick;
        alu_valid_i = 1'b0; mem_valid_i = 1'b0;
        check("pre_rst_wen", write_en_o, 64'd1);
        check("pre_rst_addr", write_addr_o, 64'd7);
        query_addr_i = 5'd8; #1;
        check("pre_rst_pending", pending_o, 64'd1);
        rst_i = 1'b1; #1;
        check("async_rst_wen", write_en_o, 64'd0);
        check("async_rst_addr", write_addr_o, 64'd0);
        check("async_rst_alu_ready", alu_ready_o, 64'd1);
        check("async_rst_mem_ready", mem_ready_o, 64'd1);
        #2 rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick;
            check("post_rst_no_stale", write_en_o, 64'd0);
            for (int q = 7; q <= 10; q++) begin
                query_addr_i = 5'(q); #1;
                check("post_rst_pending", pending_o, 64'd0);
            end
        end

        // Single ALU write latency.
        alu_valid_i = 1'b1; alu_rd_i = 5'd20; alu_data_i = 64'hBABEBEEFCAFEDEAD;
        tick;
        alu_valid_i = 1'b0;
        check("lat_not_yet", write_en_o, 64'd0);
        tick;
        check("lat_wen", write_en_o, 64'd1);
        check("lat_addr", write_addr_o, 64'd20);
        check("lat_data", write_data_o, 64'hBABEBEEFCAFEDEAD);
        tick;
        check("lat_one_cycle", write_en_o, 64'd0);

        // Pending query across push, write cycle and commit.
        alu_valid_i = 1'b1; alu_rd_i = 5'd19; alu_data_i = 64'hCAFEBABE12345678;
        query_addr_i = 5'd19; #1;
        check("pend_before_push", pending_o, 64'd0);
        tick;
        alu_valid_i = 1'b0;
        check("pend_queued", pending_o, 64'd1);
        tick;
        check("pend_wen", write_en_o, 64'd1);
        check("pend_addr", write_addr_o, 64'd19);
        check("pend_data", write_data_o, 64'hCAFEBABE12345678);
        check("pend_on_port", pending_o, 64'd1);
        query_addr_i = 5'd5; #1;
        check("pend_other_reg", pending_o, 64'd0);
        query_addr_i = 5'd19;
        tick;
        check("pend_after_commit", pending_o, 64'd0);

        // Load result to x0: slot consumed, no write, port values held.
        mem_valid_i = 1'b1; mem_rd_i = 5'd0; mem_data_i = 64'h1234567887654321;
        query_addr_i = 5'd0; #1;
        check("x0_pending_pre", pending_o, 64'd0);
        tick;
        mem_valid_i = 1'b0;
        check("x0_pending_queued", pending_o, 64'd0);
        tick;
        check("x0_wen", write_en_o, 64'd0);
        check("x0_addr_held", write_addr_o, 64'd19);
        check("x0_data_held", write_data_o, 64'hCAFEBABE12345678);
        check("x0_pending_slot", pending_o, 64'd0);
        tick;
        check("x0_wen_after", write_en_o, 64'd0);

        // Both sources streaming: strict alternation, backpressure, no loss.
        do_reset;
        stream(10, 10, 40, 1'b1);

        // ALU overfilled while MEM busy: ready drops, recovers after an ALU pop, last entry last.
        do_reset;
        stream(8, 10, 40, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
